fifo_stream_reader: RTL and testbench

- Read-side consumer of the synchronous FIFO. Issues read_en, captures data_out one cycle later, and presents words on a valid/ready stream to the downstream stage.
- A 2-entry output buffer sustains one word per cycle with zero bubbles while the FIFO is non-empty and the sink is ready.
- A flush command drains and discards the FIFO contents.

---
 rtl/fifo_stream_reader.sv | 124 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of a synchronous FIFO presenting words on a valid/ready stream.
// Optional counters/flags are enabled with FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int data_size = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [data_size-1:0] data_out,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  output logic                 read_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [data_size-1:0] out_data,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]          words_out,
  output logic [31:0]          words_dropped,
  output logic                 full_seen
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state, state_nx;
  logic [data_size-1:0] mem [2];
  logic                 head, tail;
  logic [1:0]           occ, occ_nx;
  logic                 inflight;
  logic                 pop, wr, flush_go;
  logic [2:0]           level;

  assign pop      = out_valid && out_ready;
  assign flush_go = (state == RUN) && flush;
  assign wr       = inflight && (state == RUN) && !flush;
  assign level    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign out_valid = (state == RUN) && (occ != 2'd0);
  assign out_data  = mem[head];
  assign busy      = (state == FLUSH) || inflight;

  always_comb begin
    state_nx = state;
    read_en  = 1'b0;
    occ_nx   = occ + {1'b0, wr} - {1'b0, pop};
    unique case (state)
      RUN: begin
        read_en = !fifo_empty && (level < 3'd2);
        if (flush) begin
          state_nx = FLUSH;
          occ_nx   = 2'd0;
        end
      end
      FLUSH: begin
        read_en = !fifo_empty;
        occ_nx  = 2'd0;
        if (fifo_empty && !inflight) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    // nothing may be requested while reset is held
    if (reset) read_en = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      occ        <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      inflight   <= 1'b0;
      flush_done <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else begin
      state      <= state_nx;
      occ        <= occ_nx;
      inflight   <= read_en;
      flush_done <= (state == FLUSH) && (state_nx == RUN);
      if (flush_go) begin
        head <= 1'b0;
        tail <= 1'b0;
      end else begin
        if (wr) begin
          mem[tail] <= data_out;
          tail      <= ~tail;
        end
        if (pop) head <= ~head;
      end
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [1:0] drop_n;

  // buffered words not popped this cycle plus any word landing now
  always_comb begin
    drop_n = 2'd0;
    if (flush_go)
      drop_n = occ - {1'b0, pop} + {1'b0, inflight};
    else if (state == FLUSH)
      drop_n = {1'b0, inflight};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_out     <= '0;
      words_dropped <= '0;
      full_seen     <= 1'b0;
    end else begin
      words_out     <= words_out + {31'd0, pop};
      words_dropped <= words_dropped + {30'd0, drop_n};
      if (fifo_full) full_seen <= 1'b1;
    end
  end
`else
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader driving a behavioural FIFO model.
// Expected words are queued on write and retired by a negedge monitor.
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_out = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_full = 1'b0;
  logic         read_en;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         busy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]  words_out;
  logic [31:0]  words_dropped;
  logic         full_seen;
`endif

  fifo_stream_reader #(.data_size(W)) dut (
    .clock(clock),
    .reset(reset),
    .data_out(data_out),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .read_en(read_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .flush_done(flush_done),
    .busy(busy)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .words_out(words_out),
    .words_dropped(words_dropped),
    .full_seen(full_seen)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] exp_q[$];

  int  outstanding = 0;
  bit  flushing = 0;
  int  pops = 0;
  int  rd_count = 0;
  int  valid_count = 0;
  int  done_count = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // behavioural synchronous FIFO with a registered empty flag
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      wq.delete();
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (read_en && !fifo_empty) data_out <= mq.pop_front();
      while (wq.size() != 0) mq.push_back(wq.pop_front());
      fifo_empty <= (mq.size() == 0);
      fifo_full  <= (mq.size() >= 16);
    end
  end

  // monitor: retire outputs, track words owed to the buffer
  always @(negedge clock) begin
    bit pop;
    if (reset) begin
      outstanding = 0;
      flushing = 0;
      exp_q.delete();
    end else begin
      pop = out_valid && out_ready;
      if (pop) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: got %0h, expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      if (read_en) rd_count++;
      if (out_valid) valid_count++;
      if (flush_done) begin
        done_count++;
        flushing = 0;
      end
      if (!flushing) begin
        chk("read_en_rule", read_en,
            !fifo_empty && ((outstanding - int'(pop)) < 2));
        outstanding = outstanding + int'(read_en) - int'(pop);
        chk("outstanding_le_2", outstanding <= 2, 1);
        if (flush) begin
          flushing = 1;
          outstanding = 0;
          exp_q.delete();
        end
      end else begin
        chk("valid_in_flush", out_valid, 0);
      end
    end
  end

  task automatic write_word(input logic [W-1:0] d);
    wq.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) write_word(W'(i));
  endtask

  task automatic trace(input int n, output int fr, output int rlen,
                       output int fv, output int vlen);
    fr = -1; fv = -1; rlen = 0; vlen = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #2;
      if (read_en) begin
        if (fr < 0) fr = c;
        if (c == fr + rlen) rlen++;
      end
      if (out_valid) begin
        if (fv < 0) fv = c;
        if (c == fv + vlen) vlen++;
      end
    end
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random
  task automatic drain(input int mode, input int limit);
    int c;
    for (c = 0; c < limit; c++) begin
      @(posedge clock); #1;
      unique case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (exp_q.size() == 0 && !out_valid && !busy && fifo_empty) break;
    end
    chk("drain_timeout", c < limit, 1);
  endtask

  task automatic wait_done(input int limit);
    int c;
    for (c = 0; c < limit; c++) begin
      @(posedge clock); #2;
      if (flush_done) break;
    end
    chk("flush_done_timeout", c < limit, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, rl, fv, vl, r0, v0, d0, p0, c;

    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_read_en", read_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_busy", busy, 0);

    // reset mid-stream
    preload(6);
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_read_en", read_en, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_busy", busy, 0);
    chk("async_flush_done", flush_done, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("rst_words_out", words_out, 0);
    chk("rst_words_dropped", words_dropped, 0);
    chk("rst_full_seen", full_seen, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #2;
      chk("idle_read_en", read_en, 0);
    end

    // full throughput
    p0 = pops;
    preload(16);
    trace(30, fr, rl, fv, vl);
    chk("tput_read_run", rl, 16);
    chk("tput_valid_run", vl, 16);
    chk("tput_latency", fv - fr, 2);
    drain(0, 20);
    chk("tput_pops", pops - p0, 16);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("full_seen", full_seen, 1);
`endif

    // backpressure pattern
    p0 = pops;
    preload(16);
    drain(1, 200);
    chk("bp_pops", pops - p0, 16);

    // flush with a full buffer
    out_ready = 1'b0;
    preload(8);
    for (c = 0; c < 20; c++) begin
      @(posedge clock); #2;
      if (out_valid && !read_en && !busy) break;
    end
    chk("buffer_full_timeout", c < 20, 1);
    d0 = done_count;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    r0 = rd_count;
    #1;
    chk("flush_valid_drop", out_valid, 0);
    chk("flush_busy", busy, 1);
    wait_done(30);
    chk("flush_reads", rd_count - r0, 6);
    repeat (3) @(posedge clock);
    #2 chk("flush_done_once", done_count - d0, 1);
    chk("flush_idle", busy, 0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("words_dropped", words_dropped, 8);
`endif

    // single word while idle
    out_ready = 1'b1;
    r0 = rd_count;
    v0 = valid_count;
    write_word(8'h5c);
    repeat (10) @(posedge clock);
    #2;
    chk("single_reads", rd_count - r0, 1);
    chk("single_valids", valid_count - v0, 1);
    chk("single_busy", busy, 0);

    // flush in the cycle a read lands
    out_ready = 1'b0;
    write_word(8'h3e);
    for (c = 0; c < 10; c++) begin
      @(posedge clock); #2;
      if (read_en) break;
    end
    chk("land_read_timeout", c < 10, 1);
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    wait_done(20);
    out_ready = 1'b1;
    v0 = valid_count;
    repeat (4) @(posedge clock);
    #2 chk("landed_discarded", valid_count - v0, 0);
    p0 = pops;
    write_word(8'ha5);
    drain(0, 20);
    chk("resume_pops", pops - p0, 1);

    // random traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = 1'b0;
      if (!flushing && mq.size() + wq.size() < 12 && $urandom_range(0, 2) == 0)
        write_word(W'($urandom));
      if (!flushing && $urandom_range(0, 59) == 0) flush = 1'b1;
    end
    @(posedge clock); #1 flush = 1'b0;
    for (c = 0; c < 50; c++) begin
      @(posedge clock); #2;
      if (!flushing) break;
    end
    chk("rand_flush_exit", c < 50, 1);
    drain(2, 500);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("words_out", words_out, pops);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
